// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the segment scan driver
// SEG_SCAN_FLAGS_EN adds a fourth, flag-status digit to the scan.
package seg_scan_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [1:0] digit_t;

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_e;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_OVF   = 3;

    localparam int SEG_A = 0;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_G = 6;

`ifdef SEG_SCAN_FLAGS_EN
    localparam int NUM_DIGITS = 4;
`else
    localparam int NUM_DIGITS = 3;
`endif

    // Active-low: a set flag lights (clears) its assigned segment.
    function automatic seg_t flags_to_seg(input logic [3:0] flags);
        seg_t s;
        s        = SEG_BLANK;
        s[SEG_A] = ~flags[FLAG_CARRY];
        s[SEG_G] = ~flags[FLAG_NEG];
        s[SEG_D] = ~flags[FLAG_ZERO];
        s[SEG_E] = ~flags[FLAG_OVF];
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - pattern inputs and multiplexed display outputs of the scan driver
interface seg_scan_if;
    import seg_scan_pkg::*;

    seg_t       seg0_i;
    seg_t       seg1_i;
    seg_t       seg2_i;
    logic [3:0] flags_i;
    logic       freeze_i;
    seg_t       seg_o;
    logic [3:0] an_o;
    logic       frame_o;

    modport master (
        output seg0_i, seg1_i, seg2_i, flags_i, freeze_i,
        input  seg_o, an_o, frame_o
    );

    modport slave (
        input  seg0_i, seg1_i, seg2_i, flags_i, freeze_i,
        output seg_o, an_o, frame_o
    );

endinterface

// File: rtl/seg_slot_timer.sv
// rtl/seg_slot_timer.sv - slot tick counter, digit rotation, blank/drive state and frame pulse
module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        clk,
    input  logic        rst,
    output digit_t      digit_nxt_o,
    output slot_state_e state_o,
    output slot_state_e state_nxt_o,
    output logic        snap_o,
    output logic        frame_o
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [TW-1:0] tick_q, tick_d;
    digit_t        digit_q, digit_d;
    slot_state_e   state_q, state_d;
    logic          frame_q, frame_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q  <= '0;
            digit_q <= '0;
            state_q <= SLOT_BLANK;
            frame_q <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            digit_q <= digit_d;
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    // State and frame are derived from the next tick so they line up with it once registered.
    always_comb begin
        tick_d  = tick_q + 1'b1;
        digit_d = digit_q;
        if (tick_q == TW'(DIV - 1)) begin
            tick_d  = '0;
            digit_d = (digit_q == digit_t'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
        end
        state_d = (tick_d >= TW'(BLANK)) ? SLOT_DRIVE : SLOT_BLANK;
        frame_d = (tick_d == TW'(DIV - 1)) && (digit_d == digit_t'(NUM_DIGITS - 1));
    end

    assign digit_nxt_o = digit_d;
    assign state_o     = state_q;
    assign state_nxt_o = state_d;
    assign snap_o      = (tick_q == '0) && (digit_q == '0);
    assign frame_o     = frame_q;

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 7-segment scan driver with tear-free frame snapshots
// SEG_SCAN_FLAGS_EN scans a fourth digit showing the flag shadow.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);

    digit_t      digit_nxt;
    slot_state_e state_cur, state_nxt;
    logic        snap, frame;

    seg_slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .digit_nxt_o (digit_nxt),
        .state_o     (state_cur),
        .state_nxt_o (state_nxt),
        .snap_o      (snap),
        .frame_o     (frame)
    );

    seg_t       sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    seg_t       seg_q, seg_d, pat;
    logic [3:0] an_q, an_d;
`ifdef SEG_SCAN_FLAGS_EN
    logic [3:0] flags_q, flags_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sh0_q <= SEG_BLANK;
            sh1_q <= SEG_BLANK;
            sh2_q <= SEG_BLANK;
            seg_q <= SEG_BLANK;
            an_q  <= 4'hF;
`ifdef SEG_SCAN_FLAGS_EN
            flags_q <= 4'h0;
`endif
        end else begin
            sh0_q <= sh0_d;
            sh1_q <= sh1_d;
            sh2_q <= sh2_d;
            seg_q <= seg_d;
            an_q  <= an_d;
`ifdef SEG_SCAN_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    always_comb begin
        sh0_d = sh0_q;
        sh1_d = sh1_q;
        sh2_d = sh2_q;
`ifdef SEG_SCAN_FLAGS_EN
        flags_d = flags_q;
`endif
        if (snap && !bus.freeze_i) begin
            sh0_d = bus.seg0_i;
            sh1_d = bus.seg1_i;
            sh2_d = bus.seg2_i;
`ifdef SEG_SCAN_FLAGS_EN
            flags_d = bus.flags_i;
`endif
        end

        case (digit_nxt)
            2'd0:    pat = sh0_q;
            2'd1:    pat = sh1_q;
            2'd2:    pat = sh2_q;
`ifdef SEG_SCAN_FLAGS_EN
            default: pat = flags_to_seg(flags_q);
`else
            default: pat = SEG_BLANK;
`endif
        endcase

        // Outputs are reloaded only when the slot state flips, so they can never glitch mid-slot.
        seg_d = seg_q;
        an_d  = an_q;
        if (state_nxt != state_cur) begin
            if (state_nxt == SLOT_DRIVE) begin
                seg_d = pat;
                an_d  = ~(4'b0001 << digit_nxt);
            end else begin
                seg_d = SEG_BLANK;
                an_d  = 4'hF;
            end
        end
    end

    assign bus.seg_o   = seg_q;
    assign bus.an_o    = an_q;
    assign bus.frame_o = frame;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed table plus randomized model comparison for seg_scan_driver
module tb_seg_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
`ifdef SEG_SCAN_FLAGS_EN
    localparam int N = 4;
`else
    localparam int N = 3;
`endif
    localparam int F = DIV * N;

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic [3:0] an;
        logic       frame;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan_driver #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         vectors = 0;
    int         errors  = 0;
    int         cyc     = 0;
    logic [6:0] sh [4];
    vec_t       tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] flag_pat(input logic [3:0] f);
        logic [6:0] p;
        p = 7'h7F;
        if (f[0]) p[0] = 1'b0;
        if (f[1]) p[6] = 1'b0;
        if (f[2]) p[3] = 1'b0;
        if (f[3]) p[4] = 1'b0;
        return p;
    endfunction

    // Expected display for elapsed cycles since reset: slot = cyc/DIV, position = cyc%DIV.
    task automatic model_check();
        int         t, d;
        logic [6:0] es;
        logic [3:0] ea;
        logic       ef;
        t = cyc % DIV;
        d = (cyc / DIV) % N;
        if (t < BLANK) begin
            es = 7'h7F;
            ea = 4'hF;
        end else begin
            es = sh[d];
            ea = 4'hF & ~(4'h1 << d);
        end
        ef = (t == DIV - 1) && (d == N - 1);
        chk("model_seg", {25'd0, bus.seg_o}, {25'd0, es});
        chk("model_an", {28'd0, bus.an_o}, {28'd0, ea});
        chk("model_frame", {31'd0, bus.frame_o}, {31'd0, ef});
    endtask

    task automatic advance();
        if (rst) begin
            cyc = 0;
            for (int i = 0; i < 4; i++) sh[i] = 7'h7F;
        end else begin
            if ((cyc % F) == 0 && !bus.freeze_i) begin
                sh[0] = bus.seg0_i;
                sh[1] = bus.seg1_i;
                sh[2] = bus.seg2_i;
                sh[3] = flag_pat(bus.flags_i);
            end
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl.push_back('{0, 7'h7F, 4'hF, 1'b0});
        tbl.push_back('{1, 7'h7F, 4'hF, 1'b0});
        tbl.push_back('{2, 7'h40, 4'hE, 1'b0});
        tbl.push_back('{7, 7'h40, 4'hE, 1'b0});
        tbl.push_back('{8, 7'h7F, 4'hF, 1'b0});
        tbl.push_back('{10, 7'h79, 4'hD, 1'b0});
        tbl.push_back('{15, 7'h79, 4'hD, 1'b0});
        tbl.push_back('{18, 7'h24, 4'hB, 1'b0});
`ifdef SEG_SCAN_FLAGS_EN
        tbl.push_back('{23, 7'h24, 4'hB, 1'b0});
        tbl.push_back('{26, 7'h76, 4'h7, 1'b0});
        tbl.push_back('{31, 7'h76, 4'h7, 1'b1});
        tbl.push_back('{34, 7'h40, 4'hE, 1'b0});
        tbl.push_back('{2*F+26, 7'h76, 4'h7, 1'b0});
        tbl.push_back('{3*F+26, 7'h2F, 4'h7, 1'b0});
`else
        tbl.push_back('{23, 7'h24, 4'hB, 1'b1});
        tbl.push_back('{26, 7'h40, 4'hE, 1'b0});
`endif
        tbl.push_back('{F+10, 7'h30, 4'hD, 1'b0});
        tbl.push_back('{2*F+2, 7'h40, 4'hE, 1'b0});
        tbl.push_back('{2*F+10, 7'h30, 4'hD, 1'b0});
        tbl.push_back('{3*F+2, 7'h12, 4'hE, 1'b0});
        tbl.push_back('{3*F+10, 7'h0F, 4'hD, 1'b0});

        rst          = 1'b1;
        bus.seg0_i   = 7'h40;
        bus.seg1_i   = 7'h79;
        bus.seg2_i   = 7'h24;
        bus.flags_i  = 4'b0101;
        bus.freeze_i = 1'b0;
        for (int i = 0; i < 4; i++) sh[i] = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg", {25'd0, bus.seg_o}, 32'h7F);
        chk("reset_an", {28'd0, bus.an_o}, 32'hF);
        chk("reset_frame", {31'd0, bus.frame_o}, 32'h0);
        rst = 1'b0;
        cyc = 0;

        // Rotation, tearing, ignored freeze, frozen frame, then fresh snapshot.
        for (int c = 0; c < 4 * F; c++) begin
            if (cyc == 5) bus.seg1_i = 7'h30;
            if (cyc == F + 5) bus.freeze_i = 1'b1;
            if (cyc == F + 6) bus.freeze_i = 1'b0;
            if (cyc == 2 * F) begin
                bus.freeze_i = 1'b1;
                bus.seg0_i   = 7'h12;
                bus.seg1_i   = 7'h0F;
                bus.seg2_i   = 7'h33;
                bus.flags_i  = 4'b1010;
            end
            if (cyc == 2 * F + 3) bus.freeze_i = 1'b0;
            model_check();
            foreach (tbl[i]) begin
                if (tbl[i].cyc == cyc) begin
                    chk("tbl_seg", {25'd0, bus.seg_o}, {25'd0, tbl[i].seg});
                    chk("tbl_an", {28'd0, bus.an_o}, {28'd0, tbl[i].an});
                    chk("tbl_frame", {31'd0, bus.frame_o}, {31'd0, tbl[i].frame});
                end
            end
            advance();
        end

        // Reset during digit 1 drive.
        for (int c = 0; c < 12; c++) begin
            model_check();
            advance();
        end
        rst = 1'b1;
        model_check();
        advance();
        chk("midrst_seg", {25'd0, bus.seg_o}, 32'h7F);
        chk("midrst_an", {28'd0, bus.an_o}, 32'hF);
        chk("midrst_frame", {31'd0, bus.frame_o}, 32'h0);
        advance();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            model_check();
            if (cyc == 2) begin
                chk("restart_seg", {25'd0, bus.seg_o}, 32'h12);
                chk("restart_an", {28'd0, bus.an_o}, 32'hE);
            end
            advance();
        end

        for (int c = 0; c < 3000; c++) begin
            bus.seg0_i   = 7'($urandom);
            bus.seg1_i   = 7'($urandom);
            bus.seg2_i   = 7'($urandom);
            bus.flags_i  = 4'($urandom);
            bus.freeze_i = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 299) == 0);
            model_check();
            advance();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIV, default 8'd50 × 1000 (50000), meaning clock cycles per digit slot (blank plus drive).
REQ-002 The block SHALL have parameter BLANK, default 500, meaning blanking cycles at the start of each slot; legal range 1 ≤ BLANK < DIV.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock. One clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have ports seg0_i, seg1_i and seg2_i, input, 7 bits each: active-low segment patterns for digits 0..2 (bit0=a … bit6=g).
REQ-006 The block SHALL have port flags_i, input, 4 bits: {overflow, zero, negative, carry}.
REQ-007 The block SHALL have port freeze_i, input, 1 bit: when high, it inhibits the frame snapshot.
REQ-008 The block SHALL have port seg_o, output, 7 bits: shared active-low segment bus.
REQ-009 The block SHALL have port an_o, output, 4 bits: active-low digit enables (an_o[k] selects digit k).
REQ-010 The block SHALL have port frame_o, output, 1 bit: a one-cycle pulse on the last cycle of a frame.

Function
REQ-011 Slot counter tick SHALL count 0..DIV-1 and wrap to 0; the digit index SHALL advance when tick==DIV-1.
REQ-012 Two states SHALL exist. BLANK holds while tick<BLANK and DRIVE holds while tick≥BLANK; the state is a registered function of tick.
REQ-013 In BLANK, seg_o SHALL be 7'h7F and an_o SHALL be 4'hF, with no digit enabled.
REQ-014 In DRIVE, an_o SHALL have only bit [digit] low, and seg_o SHALL equal the shadow pattern of the current digit.
REQ-015 Digit order SHALL be 0,1,2 (and 3 when SEG_SCAN_FLAGS_EN is defined), wrapping from the last digit to 0.
REQ-016 frame_o SHALL be high only on the cycle where tick==DIV-1 and the digit is the last digit.
REQ-017 Snapshot: on the cycle with digit==0, tick==0 and freeze_i==0, all inputs SHALL be registered into shadow registers.
REQ-018 Shadow registers SHALL hold otherwise, so that input changes never alter a frame already in progress (no tearing).
REQ-019 freeze_i high at the snapshot cycle SHALL retain the previous shadows for the whole next frame; freeze_i at any other cycle SHALL be ignored.
REQ-020 All outputs SHALL be registered, and seg_o/an_o SHALL change only on slot-state boundaries.

Reset
REQ-021 While rst is high, tick SHALL be 0, digit 0, state BLANK, seg_o 7'h7F, an_o 4'hF, frame_o 0, and all shadows 7'h7F (flag shadow 4'h0).
REQ-022 Reset asserted mid-DRIVE SHALL blank outputs on the next clock edge, with no partial slot and no frame_o pulse.
REQ-023 The first cycle after reset release SHALL be tick 0 of digit 0, and a snapshot SHALL occur on it (subject to freeze_i).

Configuration
REQ-024 With macro SEG_SCAN_FLAGS_EN defined, a 4th digit SHALL be scanned. Its pattern is segment a lit if carry, g if negative, d if zero, e if overflow, and all others off.
REQ-025 Without SEG_SCAN_FLAGS_EN, only 3 digits SHALL be scanned, flags_i SHALL be ignored, an_o[3] SHALL be held 1, and frame_o SHALL follow digit 2.

Structure
REQ-026 Package seg_scan_pkg SHALL hold the seg_t (7-bit) typedef, the SEG_BLANK=7'h7F constant, the flag bit-position constants and the digit-count constant.
REQ-027 Sub-module seg_slot_timer SHALL own tick, digit, state and frame_o; the top level SHALL own shadows and the output mux.

Verification (DIV=8, BLANK=2)
REQ-028 Reset: rst=1 for 3 cycles -> seg_o=7F, an_o=F. After release, cycles 0-1 show blank, and cycle 2 shows an_o=E with seg_o=seg0_i.
REQ-029 Rotation: seg0/1/2=40/79/24 -> digit0 (40, an_o=E) at cycles 2-7, digit1 (79, an_o=D) at cycles 10-15, digit2 (24, an_o=B) at cycles 18-23. frame_o pulses at cycle 23 (without the macro), and digit0 returns at cycle 26.
REQ-030 Tearing: seg1_i changes 79→30 at cycle 5 -> digit1 still shows 79 in cycles 10-15, and 30 appears in the next frame.
REQ-031 Freeze: freeze_i=1 at the frame-start cycle, with new inputs applied -> the next frame repeats the old patterns.
REQ-032 Flags (macro defined): flags_i=4'b0101 -> digit3 shows seg_o=7'h7E (a lit) AND with d-bit cleared, i.e. 7'h76, and an_o=7.
REQ-033 Mid-drive reset: rst at cycle 12 -> seg_o=7F and an_o=F at cycle 13, frame_o stays 0, and digit0 restarts after release.
